// File: rtl/fwd_arb_pkg.sv
// fwd_arb_pkg: shared definitions for the forwarder round-robin arbiter and
// the downstream mux tree.
//   - ARB_* : arbiter state encoding
//   - clog2 : select-width helper (never returns less than 1)
// Optional build macro used by the arbiter: FWD_ARB_BACK_TO_BACK_EN.
package fwd_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE    = 2'd0;
    localparam arb_state_t ARB_GRANT   = 2'd1;
    localparam arb_state_t ARB_RELEASE = 2'd2;

    // Width of a binary index able to address v entries; 1 for v <= 2.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_rr_pick.sv
// fwd_rr_pick: combinational rotating-priority finder.
// Finds the first set bit of (req & ~mask) searching upward from last+1 and
// wrapping modulo N.
//   req   [N-1:0] : request vector
//   last  [W-1:0] : index that currently has lowest priority
//   mask  [N-1:0] : requests to exclude from the search
//   found         : some unmasked request exists
//   idx   [W-1:0] : winning index (always < N)
module fwd_rr_pick
    import fwd_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    input  logic [N-1:0] mask,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;

    // Two copies of the request vector side by side: shifting right by
    // last+1 puts the search start at bit 0 and brings the wrapped-around
    // requests in above it, so a plain lowest-bit search does the rotation.
    always_comb begin
        int start;
        int off;
        int sum;
        cand  = req & ~mask;
        dbl   = {cand, cand};
        start = int'(last) + 1;
        rot   = dbl >> start;
        found = 1'b0;
        off   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = start + off;
        if (sum >= N) sum = sum - N;
        idx = W'(sum);
    end

endmodule

// File: rtl/fwd_rr_arbiter.sv
// fwd_rr_arbiter: round-robin arbiter in front of the forwarder mux tree.
// Grants one forwarder for a whole packet; the grant ends on done[sel],
// on the holder dropping req (abort), or on watchdog expiry.
//   clk, rst       : clock, asynchronous active-high reset
//   req   [N_SN]   : level requests, held until done
//   done  [N_SN]   : one-cycle end-of-packet pulses
//   gnt   [N_SN]   : registered one-hot grant
//   sel   [SEL_W]  : registered binary index of the holder (mux tree select)
//   sel_vld        : a grant is active
//   timeout        : one-cycle pulse when the watchdog forced a release
// Build macro FWD_ARB_BACK_TO_BACK_EN: hand over directly to the next
// requester on release instead of passing through the one-cycle bubble.
module fwd_rr_arbiter
    import fwd_arb_pkg::*;
#(
    parameter  int N_SN      = 4,
    parameter  int TIMEOUT   = 0,
    parameter  int TO_WIDTH  = 16,
    localparam int SEL_WIDTH = clog2(N_SN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SN-1:0]      req,
    input  logic [N_SN-1:0]      done,
    output logic [N_SN-1:0]      gnt,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 sel_vld,
    output logic                 timeout
);

`ifdef FWD_ARB_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam bit                  WD_EN   = (TIMEOUT > 0);
    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [N_SN-1:0]     ONE     = {{(N_SN-1){1'b0}}, 1'b1};

    arb_state_t            state_q, state_d;
    logic [N_SN-1:0]       gnt_q, gnt_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  vld_q, vld_d;
    logic                  to_q, to_d;
    logic [SEL_WIDTH-1:0]  last_q, last_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;

    logic                  in_grant;
    logic                  hold_done, hold_abort, wd_exp, rel;
    logic [SEL_WIDTH-1:0]  pick_last;
    logic [N_SN-1:0]       pick_mask;
    logic                  pick_found;
    logic [SEL_WIDTH-1:0]  pick_idx;

    assign in_grant   = (state_q == ARB_GRANT);
    assign hold_done  = done[sel_q];
    assign hold_abort = ~req[sel_q];
    assign wd_exp     = WD_EN && in_grant && (cnt_q == WD_LAST);
    assign rel        = hold_done | hold_abort | wd_exp;

    // While granting (handover build only) the holder is excluded and
    // becomes the lowest-priority index for the next pick.
    assign pick_last = (B2B && in_grant) ? sel_q : last_q;
    assign pick_mask = (B2B && in_grant) ? (ONE << sel_q) : '0;

    fwd_rr_pick #(.N(N_SN)) u_pick (
        .req   (req),
        .last  (pick_last),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_d   = ONE << pick_idx;
                    sel_d   = pick_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    last_d = sel_q;
                    // done or abort on the expiry cycle takes precedence
                    to_d   = wd_exp & ~hold_done & ~hold_abort;
                    if (B2B && pick_found) begin
                        gnt_d = ONE << pick_idx;
                        sel_d = pick_idx;
                        cnt_d = '0;
                    end else begin
                        // sel keeps its value so the mux tree output is stable
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                        state_d = ARB_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= SEL_WIDTH'(N_SN - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign sel_vld = vld_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_fwd_rr_arbiter.sv
module tb_fwd_rr_arbiter;

`ifdef FWD_ARB_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0, done = '0, gnt;
    logic [1:0] sel;
    logic       vld, to;
    logic [2:0] req3 = '0, done3 = '0, gnt3;
    logic [1:0] sel3;
    logic       vld3, to3;

    always #5 clk = ~clk;

    // main instance: 4 requesters, watchdog of 8 cycles
    fwd_rr_arbiter #(.N_SN(4), .TIMEOUT(8), .TO_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .sel_vld(vld), .timeout(to)
    );

    // non-power-of-two instance, watchdog disabled
    fwd_rr_arbiter #(.N_SN(3), .TIMEOUT(0), .TO_WIDTH(16)) u_n3 (
        .clk(clk), .rst(rst), .req(req3), .done(done3),
        .gnt(gnt3), .sel(sel3), .sel_vld(vld3), .timeout(to3)
    );

    typedef struct {
        string      tag;
        bit         n3;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [3:0] oh(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return one << k;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s got %h want %h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit n3, input logic [3:0] eg,
                        input logic [1:0] es, input logic ev, input logic et);
        exp_t e;
        e.tag = tag; e.n3 = n3; e.gnt = eg; e.sel = es; e.vld = ev; e.to = et;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        if (e.n3) begin
            cmp(e.tag, "gnt", {1'b0, gnt3}, e.gnt);
            cmp(e.tag, "sel", {2'b00, sel3}, {2'b00, e.sel});
            cmp(e.tag, "vld", {3'b000, vld3}, {3'b000, e.vld});
            cmp(e.tag, "to",  {3'b000, to3},  {3'b000, e.to});
        end else begin
            cmp(e.tag, "gnt", gnt, e.gnt);
            cmp(e.tag, "sel", {2'b00, sel}, {2'b00, e.sel});
            cmp(e.tag, "vld", {3'b000, vld}, {3'b000, e.vld});
            cmp(e.tag, "to",  {3'b000, to},  {3'b000, e.to});
        end
    endtask

    // drive inputs for the next edge, expect the outputs after it
    task automatic cyc(input string tag, input bit n3, input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic et);
        if (n3) begin req3 = r[2:0]; done3 = d[2:0]; end
        else    begin req  = r;      done  = d;      end
        push(tag, n3, eg, es, ev, et);
        @(posedge clk); #1;
        check_pop();
    endtask

    // end of the holder's packet with r still applied; next winner nxt
    task automatic handover(input string tag, input bit n3, input logic [3:0] r, input logic [3:0] d,
                            input int cur, input int nxt);
        if (B2B) begin
            cyc(tag, n3, r, d, oh(nxt), 2'(nxt), 1'b1, 1'b0);
        end else begin
            cyc({tag, "_rel"},  n3, r, d,    4'h0, 2'(cur), 1'b0, 1'b0);
            cyc({tag, "_idle"}, n3, r, 4'h0, 4'h0, 2'(cur), 1'b0, 1'b0);
            cyc({tag, "_gnt"},  n3, r, 4'h0, oh(nxt), 2'(nxt), 1'b1, 1'b0);
        end
    endtask

    // assert reset between edges and check the outputs drop immediately
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        req = '0; done = '0; req3 = '0; done3 = '0;
        #1;
        push(tag, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        check_pop();
        push(tag, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0);
        check_pop();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // reset state and single requester
        @(posedge clk); #1;
        do_reset("rst0");
        cyc("t1_idle", 0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        cyc("t1_idle", 0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        cyc("t1_gnt",  0, 4'b0001, 4'h0, 4'b0001, 2'd0, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc("t1_hold", 0, 4'b0001, 4'h0, 4'b0001, 2'd0, 1, 0);
        cyc("t1_done", 0, 4'b0001, 4'b0001, 4'h0, 2'd0, 0, 0);
        cyc("t1_rel",  0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        cyc("t1_idle2", 0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);

        // all four requesting: order 0,1,2,3,0
        do_reset("rst1");
        cyc("rr_gnt", 0, 4'hF, 4'h0, 4'b0001, 2'd0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++)
                cyc("rr_hold", 0, 4'hF, 4'h0, oh(k % 4), 2'(k % 4), 1, 0);
            if (k == 4) begin
                cyc("rr_last",  0, 4'h0, oh(k % 4), 4'h0, 2'(k % 4), 0, 0);
                cyc("rr_drain", 0, 4'h0, 4'h0, 4'h0, 2'(k % 4), 0, 0);
            end else begin
                handover("rr_ho", 0, 4'hF, oh(k % 4), k % 4, (k + 1) % 4);
            end
        end

        // done on a non-granted index ignored, then abort; then rotation
        do_reset("rst2");
        cyc("ab_gnt",   0, 4'b0100, 4'h0,    4'b0100, 2'd2, 1, 0);
        cyc("ab_odone", 0, 4'b0100, 4'b0010, 4'b0100, 2'd2, 1, 0);
        cyc("ab_hold",  0, 4'b0100, 4'h0,    4'b0100, 2'd2, 1, 0);
        cyc("ab_abort", 0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
        cyc("ab_rel",   0, 4'h0, 4'h0, 4'h0, 2'd2, 0, 0);
        cyc("ab_last2", 0, 4'b0101, 4'h0, 4'b0001, 2'd0, 1, 0);
        handover("rot02", 0, 4'b0101, 4'b0001, 0, 2);
        handover("rot20", 0, 4'b0101, 4'b0100, 2, 0);
        cyc("rot_end",  0, 4'h0, 4'b0001, 4'h0, 2'd0, 0, 0);
        cyc("rot_rel",  0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);

        // watchdog: 8 grant cycles then a one-cycle timeout pulse
        do_reset("rst3");
        cyc("wd_gnt", 0, 4'b0010, 4'h0, 4'b0010, 2'd1, 1, 0);
        for (int i = 0; i < 7; i++)
            cyc("wd_hold", 0, 4'b0010, 4'h0, 4'b0010, 2'd1, 1, 0);
        cyc("wd_exp",   0, 4'b0010, 4'h0, 4'h0, 2'd1, 0, 1);
        cyc("wd_rel",   0, 4'b0010, 4'h0, 4'h0, 2'd1, 0, 0);
        cyc("wd_regnt", 0, 4'b0010, 4'h0, 4'b0010, 2'd1, 1, 0);
        for (int i = 0; i < 7; i++)
            cyc("wd_hold2", 0, 4'b0010, 4'h0, 4'b0010, 2'd1, 1, 0);
        cyc("wd_done_exp", 0, 4'b0010, 4'b0010, 4'h0, 2'd1, 0, 0);
        cyc("wd_rel2",  0, 4'h0, 4'h0, 4'h0, 2'd1, 0, 0);
        cyc("wd_idle",  0, 4'h0, 4'h0, 4'h0, 2'd1, 0, 0);

        // asynchronous reset mid-grant, then priority from a fresh reset
        do_reset("rst4");
        cyc("ar_gnt",  0, 4'b0100, 4'h0, 4'b0100, 2'd2, 1, 0);
        cyc("ar_hold", 0, 4'b0100, 4'h0, 4'b0100, 2'd2, 1, 0);
        do_reset("ar_mid");
        cyc("ar_g3",   0, 4'b1000, 4'h0, 4'b1000, 2'd3, 1, 0);
        cyc("ar_d3",   0, 4'h0, 4'b1000, 4'h0, 2'd3, 0, 0);
        cyc("ar_rel",  0, 4'h0, 4'h0, 4'h0, 2'd3, 0, 0);
        cyc("ar_g0",   0, 4'b1001, 4'h0, 4'b0001, 2'd0, 1, 0);
        cyc("ar_hold0", 0, 4'b1001, 4'h0, 4'b0001, 2'd0, 1, 0);
        handover("ar_ho", 0, 4'b1001, 4'b0001, 0, 3);
        cyc("ar_end",  0, 4'h0, 4'b1000, 4'h0, 2'd3, 0, 0);
        cyc("ar_rel2", 0, 4'h0, 4'h0, 4'h0, 2'd3, 0, 0);

        // three requesters: sel takes 2 then 0, no watchdog release
        do_reset("rst5");
        cyc("n3_g2", 1, 4'b0100, 4'h0, 4'b0100, 2'd2, 1, 0);
        for (int i = 0; i < 10; i++)
            cyc("n3_hold", 1, 4'b0101, 4'h0, 4'b0100, 2'd2, 1, 0);
        handover("n3_ho", 1, 4'b0101, 4'b0100, 2, 0);
        cyc("n3_end",  1, 4'h0, 4'b0001, 4'h0, 2'd0, 0, 0);
        cyc("n3_rel",  1, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0);
        cyc("n3_g1",   1, 4'b0010, 4'h0, 4'b0010, 2'd1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_rr_arbiter.md
Name: fwd_rr_arbiter

Overview:
- Round-robin arbiter directly upstream of the forwarder mux tree.
- Grants one of N packet-filter forwarders exclusive access to the shared output and drives the binary select consumed by every mux_tree_node level.
- Holds the grant for a whole packet until the granted forwarder signals done, aborts, or a watchdog expires.

Parameters:
- N_SN, 4, number of requesting forwarders (2..64).
- SEL_WIDTH, $clog2(N_SN), width of binary select; derived, not overridden.
- TIMEOUT, 0, max cycles a grant may be held; 0 disables the watchdog.
- TO_WIDTH, 16, width of watchdog counter; TIMEOUT must be < 2^TO_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_SN  per-forwarder request, level; held until done.
- done  input  N_SN  per-forwarder single-cycle end-of-packet pulse.
- gnt  output  N_SN  one-hot grant, registered.
- sel  output  SEL_WIDTH  binary index of granted forwarder, registered; feeds mux tree.
- sel_vld  output  1  high while any grant active.
- timeout  output  1  single-cycle pulse when the watchdog forces release.

Behaviour:
- Reset (async, immediate): gnt=0, sel=0, sel_vld=0, timeout=0, state=IDLE, last=N_SN-1 (so index 0 has highest priority first), watchdog count=0.
- States: IDLE, GRANT, RELEASE.
- IDLE: if req!=0, the winner is the first set bit searching upward from last+1, wrapping modulo N_SN. On that edge: gnt=onehot(winner), sel=winner, sel_vld=1, state=GRANT. Latency from req assertion to gnt is 1 cycle.
- GRANT, done[sel]=1: next edge gnt=0, sel_vld=0, last=sel, state=RELEASE.
- GRANT, req[sel]=0 without done (abort): same as done.
- GRANT, done on a non-granted index: ignored.
- GRANT, watchdog: counts cycles in GRANT. When count==TIMEOUT-1 and no done/abort, release as above and assert timeout for 1 cycle. If done arrives on the same cycle as expiry, done wins and timeout stays 0.
- RELEASE: one bubble cycle with sel held at its last value (mux tree output stable), then IDLE. sel is never changed while sel_vld=1.
- Winner after release: the granted index becomes lowest priority.
  - req=4'b0101, last=0 → grant 2, then 0.
  - A sole requester re-wins after the bubble.
- Minimum gap between grants: 2 cycles (RELEASE + IDLE evaluation) without the optional feature.
- N_SN not a power of two: sel never exceeds N_SN-1.
- Reset mid-packet: grant dropped asynchronously; the forwarder must re-request.

Optional Feature:
- Macro FWD_ARB_BACK_TO_BACK_EN.
- Defined: RELEASE is skipped. On the done/abort/timeout edge the arbiter directly loads the next winner, computed with the current holder masked out and last=sel. gnt switches one-hot to one-hot and sel_vld stays high, giving zero-bubble handover. If no other request is pending, behave as without the macro (go idle).
- Undefined: behaviour exactly as above.

Decomposition:
- Package fwd_arb_pkg:
  - state encoding localparams ARB_IDLE=2'd0, ARB_GRANT=2'd1, ARB_RELEASE=2'd2;
  - the clog2 helper function;
  - shared by the mux tree for SEL_WIDTH.
- Sub-module fwd_rr_pick: purely combinational rotating-priority finder.
  - Inputs: req, last, mask.
  - Outputs: found, idx.
  - Double-width request vector technique.
  - Instantiated once.

Test Plan:
- Reset then req=4'b0001 at cycle 3 → gnt=4'b0001, sel=0, sel_vld=1 at cycle 4; done[0] pulse at cycle 10 → gnt=0 at cycle 11, sel stays 0 until the next grant.
- req=4'b1111 held, each granted forwarder pulses done 5 cycles after its grant → grant order 0,1,2,3,0; gap between grants 2 cycles (0 with FWD_ARB_BACK_TO_BACK_EN).
- Granted index 2 with done[1] pulsed → no change; then req[2] dropped → release next edge, last=2.
- TIMEOUT=8, req=4'b0010 held with no done → gnt released after 8 grant cycles, timeout high 1 cycle; done on the expiry cycle → timeout stays 0.
- N_SN=3, req=3'b100 then 3'b101 → sel takes only 2 then 0, never 3.
- rst asserted asynchronously mid-grant (between clock edges) → gnt=0, sel_vld=0 immediately; after release, req=4'b1000 wins first, then index 0 before 3 on contention.
